fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end for the five-stage pipeline. It owns the program counter, issues word reads to the instruction memory, and buffers the returned words in a small prefetch queue. It presents instruction/PC+4 pairs to the ID stage through a valid/ready handshake. A redirect from the branch-resolution stage flushes the queue and squashes any in-flight read.

---
 rtl/fetch_prefetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC, imem read issue, prefetch queue.
// Ports: clk/rst, imem_req/addr/rdata, redirect/redirect_pc, id_valid/instr/pc_plus4/ready.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  input  logic        id_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          squash_q, squash_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  logic [AW+1:0] occ;
  logic          issue;
  logic          push;
  logic          pop;
  logic          has_head;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Words owned by the queue plus the one on its way back.
  assign occ = {1'b0, count_q}
             + (AW+2)'(inflight_q);

  assign issue = rst & ~redirect
               & (occ < DEPTH_C);

  // A return is dropped if its read
  // predates a redirect.
  assign push = inflight_q & ~squash_q
              & ~redirect;

  assign has_head = (count_q != '0);
  assign id_valid = has_head & ~redirect;
  assign pop      = id_valid & id_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign id_instr =
    has_head ? instr_mem[rptr_q] : '0;
  assign id_pc_plus4 =
    has_head ? pc4_mem[rptr_q] : '0;

  always_comb begin
    pc_d          = pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    squash_d      = redirect;

    if (issue) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
    end

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);

    unique case (1'b1)
      (push & ~pop): count_d = count_q + 1'b1;
      (pop & ~push): count_d = count_q - 1'b1;
      default:       count_d = count_q;
    endcase

    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      instr_mem[wptr_q] <= imem_rdata;
      pc4_mem[wptr_q]   <= inflight_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit.
// Vector table plus hand sequences for backpressure and reset.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4),
    .id_ready(id_ready)
  );

  // word[k] = k + 100, one-cycle read latency
  always @(posedge clk)
    imem_rdata <= imem_req ?
      (imem_addr >> 2) + 32'd100 : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic r, input logic d,
    input logic [31:0] p, input logic y,
    input logic c, input logic q,
    input logic [31:0] a, input logic v,
    input logic [31:0] i, input logic [31:0] p4);
    vec_t t;
    t.rst = r; t.rdr = d; t.rpc = p; t.rdy = y;
    t.chk = c; t.req = q; t.addr = a; t.v = v;
    t.instr = i; t.pc4 = p4;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    // rst rdr rpc rdy | chk req addr v instr pc4
    tbl[0]  = mk(0,0,0,1, 0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,1, 1,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,1, 1,1,32'h00,0,0,0);
    tbl[3]  = mk(1,0,0,1, 1,1,32'h04,0,0,0);
    tbl[4]  = mk(1,0,0,1, 1,1,32'h08,1,100,4);
    tbl[5]  = mk(1,0,0,1, 1,1,32'h0C,1,101,8);
    tbl[6]  = mk(1,1,32'h40,1,
                 1,0,32'h10,0,102,32'h0C);
    tbl[7]  = mk(1,0,0,1, 1,1,32'h40,0,0,0);
    tbl[8]  = mk(1,0,0,1, 1,1,32'h44,0,0,0);
    tbl[9]  = mk(1,0,0,1,
                 1,1,32'h48,1,116,32'h44);
    tbl[10] = mk(1,1,32'h47,1,
                 1,0,32'h4C,0,117,32'h48);
    tbl[11] = mk(1,0,0,1, 1,1,32'h44,0,0,0);
    tbl[12] = mk(1,0,0,1, 1,1,32'h48,0,0,0);
    tbl[13] = mk(1,0,0,1,
                 1,1,32'h4C,1,117,32'h48);
    tbl[14] = mk(1,1,32'hFFFF_FFFC,1,
                 1,0,32'h50,0,118,32'h4C);
    tbl[15] = mk(1,0,0,1,
                 1,1,32'hFFFF_FFFC,0,0,0);
    tbl[16] = mk(1,0,0,1, 1,1,32'h0,0,0,0);
    tbl[17] = mk(1,0,0,1,
                 1,1,32'h4,1,32'h4000_0063,0);
    tbl[18] = mk(1,0,0,1, 1,1,32'h8,1,100,4);

    rst = 0; redirect = 0;
    redirect_pc = 0; id_ready = 1;
    next_cyc();

    for (int i = 0; i < 19; i++) begin
      rst         = tbl[i].rst;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      id_ready    = tbl[i].rdy;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.req", i),
            32'(imem_req), 32'(tbl[i].req));
        chk($sformatf("v%0d.addr", i),
            imem_addr, tbl[i].addr);
        chk($sformatf("v%0d.valid", i),
            32'(id_valid), 32'(tbl[i].v));
        chk($sformatf("v%0d.instr", i),
            id_instr, tbl[i].instr);
        chk($sformatf("v%0d.pc4", i),
            id_pc_plus4, tbl[i].pc4);
      end
      next_cyc();
    end

    // Backpressure from reset release
    redirect = 0; rst = 0; id_ready = 0;
    next_cyc();
    rst = 1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) k++;
      next_cyc();
    end
    @(negedge clk);
    chk("bp.nreq", k, 4);
    chk("bp.req_off", 32'(imem_req), 0);
    chk("bp.valid", 32'(id_valid), 1);
    chk("bp.head", id_instr, 100);
    chk("bp.head_pc4", id_pc_plus4, 4);
    next_cyc();

    id_ready = 1;
    k = 0;
    @(negedge clk);
    for (int c = 0; c < 20 && k < 8; c++) begin
      if (c == 0) chk("bp.m_req", 32'(imem_req), 0);
      if (c == 1) chk("bp.m1_req", 32'(imem_req), 1);
      if (id_valid) begin
        chk($sformatf("bp.instr%0d", k),
            id_instr, 32'(100 + k));
        chk($sformatf("bp.pc4_%0d", k),
            id_pc_plus4, 32'(4 * (k + 1)));
        k++;
      end
      next_cyc();
      @(negedge clk);
    end
    chk("bp.delivered", k, 8);
    next_cyc();

    // Reset with queue filling and a read in flight
    id_ready = 0;
    redirect = 1; redirect_pc = 32'h80;
    next_cyc();
    redirect = 0;
    next_cyc();
    next_cyc();
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("rm.pre_valid", 32'(id_valid), 1);
    chk("rm.pre_head", id_instr, 132);
    next_cyc();
    @(negedge clk);
    chk("rm.valid", 32'(id_valid), 0);
    chk("rm.addr", imem_addr, 0);
    next_cyc();
    rst = 1; id_ready = 1;
    k = 0;
    @(negedge clk);
    for (int c = 0; c < 15 && k < 4; c++) begin
      if (id_valid) begin
        chk($sformatf("rm.instr%0d", k),
            id_instr, 32'(100 + k));
        chk($sformatf("rm.pc4_%0d", k),
            id_pc_plus4, 32'(4 * (k + 1)));
        k++;
      end
      next_cyc();
      @(negedge clk);
    end
    chk("rm.delivered", k, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
